// File: rtl/rotating_register_file.sv
// Multi-port register file with rotating-base addressing, priority write
// conflict resolution with reporting, optional write-to-read bypass and stall.
module rotating_register_file #(
  parameter int NUM_IN   = 6,
  parameter int NUM_OUT  = 12,
  parameter int LOG2REGS = 3,
  parameter int SIZE     = 32,
  parameter int BYPASS   = 1
) (
  input  logic                         CGRA_Clock,
  input  logic                         CGRA_Reset,
  input  logic                         stall,
  input  logic                         rotate,
  input  logic [NUM_IN-1:0]            WE,
  input  logic [NUM_IN*LOG2REGS-1:0]   address_in,
  input  logic [NUM_IN*SIZE-1:0]       in,
  input  logic [NUM_OUT*LOG2REGS-1:0]  address_out,
  output logic [NUM_OUT*SIZE-1:0]      out,
  output logic [LOG2REGS-1:0]          base,
  output logic                         conflict,
  output logic                         conflict_sticky
);

  localparam int DEPTH = 2**LOG2REGS;

  logic [SIZE-1:0]         regs_q [DEPTH];
  logic [SIZE-1:0]         regs_d [DEPTH];
  logic [LOG2REGS-1:0]     base_q, base_d;
  logic [NUM_OUT*SIZE-1:0] out_q, out_d;
  logic                    conflict_q, conflict_d;
  logic                    sticky_q;
  logic [LOG2REGS-1:0]     phys_in  [NUM_IN];
  logic [LOG2REGS-1:0]     phys_out [NUM_OUT];

  // Logical-to-physical mapping wraps naturally in LOG2REGS bits.
  always_comb begin
    for (int k = 0; k < NUM_IN; k++)
      phys_in[k] = address_in[k*LOG2REGS +: LOG2REGS] + base_q;
    for (int j = 0; j < NUM_OUT; j++)
      phys_out[j] = address_out[j*LOG2REGS +: LOG2REGS] + base_q;
  end

  // Ascending port order makes the highest-numbered enabled port win.
  always_comb begin
    regs_d = regs_q;
    for (int k = 0; k < NUM_IN; k++)
      if (WE[k]) regs_d[phys_in[k]] = in[k*SIZE +: SIZE];
  end

  always_comb begin
    conflict_d = 1'b0;
    for (int k = 0; k < NUM_IN; k++)
      for (int m = k + 1; m < NUM_IN; m++)
        if (WE[k] && WE[m] && (phys_in[k] == phys_in[m])) conflict_d = 1'b1;
  end

  // Bypass reads the post-write image, so the winning port's data is returned.
  always_comb begin
    out_d = '0;
    for (int j = 0; j < NUM_OUT; j++)
      out_d[j*SIZE +: SIZE] = (BYPASS != 0) ? regs_d[phys_out[j]] : regs_q[phys_out[j]];
  end

  assign base_d = rotate ? base_q + 1'b1 : base_q;

  always_ff @(posedge CGRA_Clock or posedge CGRA_Reset) begin
    if (CGRA_Reset) begin
      for (int r = 0; r < DEPTH; r++) regs_q[r] <= '0;
      base_q     <= '0;
      out_q      <= '0;
      conflict_q <= 1'b0;
      sticky_q   <= 1'b0;
    end else if (!stall) begin
      for (int r = 0; r < DEPTH; r++) regs_q[r] <= regs_d[r];
      base_q     <= base_d;
      out_q      <= out_d;
      conflict_q <= conflict_d;
      sticky_q   <= sticky_q | conflict_d;
    end
  end

  assign out             = out_q;
  assign base            = base_q;
  assign conflict        = conflict_q;
  assign conflict_sticky = sticky_q;

endmodule

// File: tb/tb_rotating_register_file.sv
// Directed bench for rotating_register_file: one bypassing and one
// non-bypassing instance share the same stimulus.
module tb_rotating_register_file;

  logic         clk;
  logic         rst;
  logic         stall;
  logic         rotate;
  logic [5:0]   we;
  logic [17:0]  addr_wr;
  logic [191:0] wr_data;
  logic [35:0]  addr_rd;
  logic [383:0] rd_b1, rd_b0;
  logic [2:0]   base_b1, base_b0;
  logic         conf_b1, conf_b0, stk_b1, stk_b0;

  int vectors = 0;
  int errors  = 0;

  rotating_register_file #(.NUM_IN(6), .NUM_OUT(12), .LOG2REGS(3), .SIZE(32), .BYPASS(1)) dut_b1 (
    .CGRA_Clock(clk), .CGRA_Reset(rst), .stall(stall), .rotate(rotate),
    .WE(we), .address_in(addr_wr), .in(wr_data), .address_out(addr_rd),
    .out(rd_b1), .base(base_b1), .conflict(conf_b1), .conflict_sticky(stk_b1));

  rotating_register_file #(.NUM_IN(6), .NUM_OUT(12), .LOG2REGS(3), .SIZE(32), .BYPASS(0)) dut_b0 (
    .CGRA_Clock(clk), .CGRA_Reset(rst), .stall(stall), .rotate(rotate),
    .WE(we), .address_in(addr_wr), .in(wr_data), .address_out(addr_rd),
    .out(rd_b0), .base(base_b0), .conflict(conf_b0), .conflict_sticky(stk_b0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = '0; addr_wr = '0; wr_data = '0; addr_rd = '0; rotate = 1'b0; stall = 1'b0;
  endtask

  task automatic wr(input int p, input logic [2:0] a, input logic [31:0] d);
    we[p] = 1'b1;
    addr_wr[p*3 +: 3] = a;
    wr_data[p*32 +: 32] = d;
  endtask

  task automatic rd(input int p, input logic [2:0] a);
    addr_rd[p*3 +: 3] = a;
  endtask

  function automatic logic [31:0] o1(input int p);
    return rd_b1[p*32 +: 32];
  endfunction

  function automatic logic [31:0] o0(input int p);
    return rd_b0[p*32 +: 32];
  endfunction

  initial begin
    idle();
    rst = 1'b1;
    #12 rst = 1'b0;
    step();
    chk("por_out_b1", rd_b1, '0);
    chk("por_out_b0", rd_b0, '0);
    chk("por_base", {381'd0, base_b1}, 384'd0);
    chk("por_conflict", {382'd0, conf_b1, stk_b1}, 384'd0);

    // basic write then read next cycle
    wr(0, 3'd5, 32'hDEADBEEF);
    wr(5, 3'd2, 32'h12345678);
    step();
    idle();
    rd(0, 3'd5); rd(11, 3'd2); rd(1, 3'd4);
    step();
    chk("basic_p0_b1", o1(0), 32'hDEADBEEF);
    chk("basic_p11_b1", o1(11), 32'h12345678);
    chk("basic_p0_b0", o0(0), 32'hDEADBEEF);
    chk("basic_p11_b0", o0(11), 32'h12345678);
    chk("basic_unwritten", o1(1), 32'h0);

    // three-way conflict on addr 7
    idle();
    wr(1, 3'd7, 32'h11); wr(3, 3'd7, 32'h33); wr(4, 3'd7, 32'h44);
    rd(0, 3'd7);
    step();
    chk("conf_flag_b1", {383'd0, conf_b1}, 384'd1);
    chk("conf_flag_b0", {383'd0, conf_b0}, 384'd1);
    chk("conf_sticky", {383'd0, stk_b1}, 384'd1);
    chk("conf_bypass_data", o1(0), 32'h44);
    chk("conf_nobypass_old", o0(0), 32'h0);
    idle();
    rd(0, 3'd7);
    step();
    chk("conf_pulse_end", {383'd0, conf_b1}, 384'd0);
    chk("conf_sticky_hold", {383'd0, stk_b1}, 384'd1);
    chk("conf_winner_b1", o1(0), 32'h44);
    chk("conf_winner_b0", o0(0), 32'h44);

    // same-cycle write/read of addr 3
    idle();
    wr(2, 3'd3, 32'hA5A5A5A5);
    rd(4, 3'd3);
    step();
    chk("byp_new_b1", o1(4), 32'hA5A5A5A5);
    chk("byp_old_b0", o0(4), 32'h0);
    idle();
    rd(4, 3'd3);
    step();
    chk("byp_late_b0", o0(4), 32'hA5A5A5A5);

    // asynchronous reset between edges
    #2 rst = 1'b1;
    #1;
    chk("arst_out_b1", rd_b1, '0);
    chk("arst_out_b0", rd_b0, '0);
    chk("arst_flags", {381'd0, base_b1, stk_b1 | conf_b1}, 384'd0);
    #1 rst = 1'b0;
    idle();
    rd(0, 3'd5); rd(1, 3'd7); rd(2, 3'd3);
    step();
    chk("arst_read", rd_b1, '0);

    // rotation wrap
    for (int i = 0; i < 8; i++) begin
      idle();
      wr(0, 3'(i), 32'h100 + 32'(i));
      step();
    end
    idle();
    rotate = 1'b1;
    for (int i = 0; i < 7; i++) step();
    chk("rot_base7", {381'd0, base_b1}, 384'd7);
    step();
    chk("rot_base_wrap", {381'd0, base_b1}, 384'd0);
    step();
    chk("rot_base9", {381'd0, base_b1}, 384'd1);
    idle();
    rd(0, 3'd0); rd(1, 3'd7);
    step();
    chk("rot_l0_b1", o1(0), 32'h101);
    chk("rot_l7_b1", o1(1), 32'h100);
    chk("rot_l0_b0", o0(0), 32'h101);
    chk("rot_l7_b0", o0(1), 32'h100);

    // stall freezes everything
    stall = 1'b1; rotate = 1'b1;
    for (int p = 0; p < 6; p++) wr(p, 3'd0, 32'hFFFFFFFF);
    rd(0, 3'd2); rd(1, 3'd2);
    step(); step(); step();
    chk("stall_base", {381'd0, base_b1}, 384'd1);
    chk("stall_out0", o1(0), 32'h101);
    chk("stall_out1", o1(1), 32'h100);
    chk("stall_conf", {382'd0, conf_b1, stk_b1}, 384'd0);
    idle();
    rd(0, 3'd0); rd(1, 3'd7);
    step();
    chk("unstall_l0", o1(0), 32'h101);
    chk("unstall_l7", o1(1), 32'h100);
    idle();
    wr(0, 3'd0, 32'hCAFE);
    rd(0, 3'd0);
    rotate = 1'b1;
    step();
    chk("resume_base", {381'd0, base_b1}, 384'd2);
    chk("resume_b1", o1(0), 32'hCAFE);
    chk("resume_b0", o0(0), 32'h101);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/rotating_register_file.md
# rotating_register_file

Parametrised multi-port register file for the CGRA processing element. It generalises the fixed 6-write/12-read, 8×32b register file to any port count, depth and width. It adds rotating-register addressing for modulo-scheduled loops, deterministic write-conflict resolution with reporting, an optional write-to-read bypass, a stall input, and reset of the read outputs. It sits between the PE's functional units and the routing crossbar: FU results are written in, and operands are read out one cycle later.

## Interface
- NUM_IN, 6, number of write ports (≥1)
- NUM_OUT, 12, number of read ports (≥1)
- LOG2REGS, 3, log2 of register count; depth = 2**LOG2REGS
- SIZE, 32, data width in bits
- BYPASS, 1, 1 = read of a same-cycle write returns the new data; 0 = returns the old data

Ports:
- CGRA_Clock  in  1  clock; all state changes on the rising edge
- CGRA_Reset  in  1  reset, asynchronous, active-high
- stall  in  1  1 = freeze all state (no writes, no rotate, outputs hold)
- rotate  in  1  1 = advance rotation base by one at the end of this cycle
- WE  in  NUM_IN  per-port write enable; bit k belongs to port k
- address_in  in  NUM_IN*LOG2REGS  logical write addresses; port k occupies bits [k*LOG2REGS +: LOG2REGS]
- in  in  NUM_IN*SIZE  write data; port k occupies bits [k*SIZE +: SIZE]
- address_out  in  NUM_OUT*LOG2REGS  logical read addresses, packed the same way
- out  out  NUM_OUT*SIZE  registered read data, packed the same way
- base  out  LOG2REGS  current rotation base
- conflict  out  1  registered; high for one cycle after a cycle in which ≥2 enabled ports wrote the same physical register
- conflict_sticky  out  1  set by any conflict; cleared only by reset

## Operation
- Address mapping: physical = (logical + base) mod 2**LOG2REGS, computed with LOG2REGS-bit wrap-around arithmetic. Read and write ports use the same mapping.
- Every address in a cycle uses the base value from the start of that cycle.
- Rotation: when rotate=1 and stall=0, base ← base+1 mod depth, so base wraps from depth-1 to 0.
- Writes: for each k with WE[k]=1 and stall=0, register[phys_in k] ← in[k].
- Write conflict: when several enabled ports target the same physical register, the highest-numbered port wins. The conflict flag is raised the next cycle.
- Reads: each port's out ← value of register[phys_out j]. The value is registered and updates every non-stalled cycle.
- With BYPASS=1, a read whose physical address matches a same-cycle write returns the winning write data. With BYPASS=0 it returns the pre-write contents.
- Stall: registers, base, out, conflict and conflict_sticky all hold, and conflict does not pulse. WE and rotate are ignored.
- Reset: all registers, out, base, conflict and conflict_sticky go to 0 immediately, regardless of the clock. Reset asserted mid-operation discards any in-flight write. The first edge after reset deassertion behaves as a normal cycle.

## Timing
- Read latency is 1 cycle: address_out is sampled at edge N and out is valid after edge N.
- Write-to-read latency:
  - 1 cycle with BYPASS=1 (same-edge).
  - 2 cycles with BYPASS=0: a read at edge N+1 sees a write from edge N.
- Rotation takes effect on the edge after rotate is sampled. A write at logical address a with base b is read back at logical address a-1 after one rotation.
- conflict is valid the cycle after the offending write. conflict_sticky rises on the same edge as conflict.
- No combinational path exists from any input to any output.

## Test plan
- Reset/idle: assert CGRA_Reset mid-cycle → out=0 on all ports, base=0, both conflict flags 0 immediately. Read any address after reset → 0.
- Basic write/read: port 0 writes 0xDEADBEEF to addr 5, port 5 writes 0x12345678 to addr 2; read addr 5 and 2 on ports 0 and 11 next cycle → 0xDEADBEEF and 0x12345678. Unwritten addresses read 0.
- Conflict priority: ports 1, 3 and 4 all write addr 7 with 0x11, 0x33 and 0x44 → register holds 0x44; conflict=1 for exactly one cycle; conflict_sticky stays 1 until reset.
- Bypass: same-cycle write 0xA5A5A5A5 to addr 3 and read of addr 3 → out=0xA5A5A5A5 with BYPASS=1. With BYPASS=0, out shows the previous value, then 0xA5A5A5A5 one cycle later.
- Rotation wrap: write 0x100+i to logical i (base 0), then pulse rotate 9 times with depth 8 → base=1; logical 0 reads 0x101, logical 7 reads 0x100.
- Stall: with stall=1, drive WE=all-ones and rotate=1 for 3 cycles → contents, base and out unchanged. Deassert stall → normal operation resumes on the next edge.
